dot_operand_streamer: RTL and testbench
=======================================

Name: dot_operand_streamer

Overview:
- Upstream feeder for the 8-wide float dot-product engine.
- On `start`, fetches one matrix row and the operand vector from two synchronous-read RAMs, one package per word.
- Presents the packages to the engine with the engine's read-now/pacing protocol, waits for the engine's finish, then returns the scalar result.
- One instance per row-times-vector product in the matrix-vector pipeline.

Parameters:
- ELEMENT_WIDTH, 32, bits per IEEE-754 single element
- NO_OF_UNITS, 8, elements per package (power of 2, ≥2)
- ADDR_W, 10, RAM word-address width (one word = one package)
- HOLD_CYCLES, 2, cycles each package is held stable (engine consumes half-packages on alternate cycles)
- TIMEOUT, 1024, max cycles waiting for dp_finish after last package

Ports:
- clk  in  1  clock, all logic posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- row_base  in  ADDR_W  first word address of row in row RAM
- vec_base  in  ADDR_W  first word address of vector in vec RAM
- total  in  32  element count of the product
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse at end of run
- error  out  1  valid with done; 1 = bad total or timeout
- result  out  ELEMENT_WIDTH  dot product, valid with done when error=0
- row_rd_en / vec_rd_en  out  1  RAM read enables
- row_rd_addr / vec_rd_addr  out  ADDR_W  RAM addresses
- row_rd_data / vec_rd_data  in  ELEMENT_WIDTH*NO_OF_UNITS  RAM data, valid 1 cycle after enable
- dp_reset  out  1  engine reset pulse
- dp_read_now  out  1  stream-start strobe to engine
- dp_first_row / dp_second_row  out  ELEMENT_WIDTH*NO_OF_UNITS  package to engine
- dp_total  out  32  registered copy of total
- dp_result  in  ELEMENT_WIDTH  engine output
- dp_finish  in  1  engine finish level

Behaviour:
- Reset clears all outputs, package registers and dp_total to 0; FSM to IDLE. Reset mid-run aborts with no done pulse.
- Let P = total/NO_OF_UNITS.
- States: IDLE, CHECK, CLEAR, PREFETCH, STREAM, WAIT_RES, DONE.
- IDLE → CHECK on start. Latch bases and total; drive dp_total = total.
- CHECK, 1 cycle:
  - total==0 or total mod NO_OF_UNITS ≠ 0 → DONE with error=1, result=0, no RAM reads, no dp_reset.
  - Otherwise → CLEAR.
- CLEAR: dp_reset=1 for 2 cycles. The engine's sticky finish must be clear before streaming. → PREFETCH.
- PREFETCH:
  - Issue read of word 0 on both RAMs (rd_en=1, addr=base).
  - Next cycle, capture rd_data into the dp_* package registers. → STREAM.
- STREAM:
  - Package k is stable on dp_first_row/dp_second_row for exactly HOLD_CYCLES cycles, starting at cycle S+HOLD_CYCLES·k. S is the first STREAM cycle.
  - No gaps or bubbles between packages.
  - dp_read_now=1 only in cycle S.
  - Read of word k+1 (addr=base+k+1) is issued so its data lands exactly at the package boundary. Data is never registered early over a held package.
  - Addresses wrap modulo 2^ADDR_W.
  - After package P-1's final hold cycle, drive packages to 0 → WAIT_RES.
- WAIT_RES:
  - First cycle with dp_finish=1 → capture result=dp_result, → DONE error=0.
  - Counter reaching TIMEOUT → DONE error=1, result unchanged.
  - dp_finish high during STREAM is ignored.
- DONE: done=1 for one cycle, busy=1 → IDLE.
- start while busy is ignored. start in the same cycle as reset is ignored.
- rd_en is low in every cycle no read is issued. RAM addresses hold their last value when idle.

Decomposition:
- Shared package `dp_pkg`:
  - ELEMENT_WIDTH, NO_OF_UNITS
  - the FSM state enum
  - package-width localparam (ELEMENT_WIDTH*NO_OF_UNITS)
- One natural sub-module, `package_pacer`. It is a hold-cycle counter plus package index. It outputs the `advance` and `last_package` strobes, reused by the downstream result-collector.
- FSM, address generation and timeout stay in the top.

Test Plan:
- total=16, row_base=4, vec_base=0, HOLD_CYCLES=2:
  - reads at addr 4,5 / 0,1;
  - each package held 2 cycles, back-to-back;
  - dp_read_now single cycle at S;
  - dp_finish after 20 cycles with dp_result=0x41200000 → done 1 cycle later, result=0x41200000, error=0.
- total=12 → done 2 cycles after start, error=1, no rd_en ever high, no dp_reset.
- total=0 → same as above, result=0.
- total=8, dp_finish never asserted, TIMEOUT=16 → done exactly 16 cycles after WAIT_RES entry, error=1.
- row_base=2^ADDR_W−1, total=16 → second read address 0 (wrap).
- Reset asserted in STREAM → next cycle all outputs 0, state IDLE. Subsequent start with total=8 completes normally. start pulsed during busy has no effect.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared constants, FSM encoding and total-count check for the dot-product operand streamer.
package dp_pkg;

   localparam int ELEMENT_WIDTH = 32;
   localparam int NO_OF_UNITS   = 8;
   localparam int PKG_W         = ELEMENT_WIDTH * NO_OF_UNITS;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      CLEAR,
      PREFETCH,
      STREAM,
      WAIT_RES,
      DONE
   } state_t;

   // A run is only meaningful for a non-empty product made of whole packages.
   function automatic logic total_ok(input logic [31:0] total, input int units);
      return (total != 32'd0) && ((total % 32'(units)) == 32'd0);
   endfunction

endpackage

// File: rtl/package_pacer.sv
// Paces operand packages: counts hold cycles of the current package and tracks its index.
// The advance/last_package strobes are also used by the downstream result collector.
module package_pacer #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] package_count,
   output logic        first,
   output logic        fetch,
   output logic        advance,
   output logic        last_package,
   output logic [31:0] index
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   logic [HW-1:0] hold_cnt;

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         hold_cnt <= '0;
         index    <= '0;
      end else if (advance) begin
         hold_cnt <= '0;
         index    <= index + 32'd1;
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign advance      = enable && (hold_cnt == HW'(HOLD_CYCLES - 1));
   assign last_package = (index == package_count - 32'd1);
   assign first        = enable && (hold_cnt == '0) && (index == 32'd0);
   // Two cycles before the boundary: RAM latency plus the capture register.
   assign fetch        = enable && (hold_cnt == HW'(HOLD_CYCLES - 2)) && !last_package;

endmodule

// File: rtl/dot_operand_streamer.sv
// Streams one matrix row and the operand vector, package by package, into the float
// dot-product engine, then returns the engine's scalar result with done/error.
module dot_operand_streamer #(
   parameter int ELEMENT_WIDTH = dp_pkg::ELEMENT_WIDTH,
   parameter int NO_OF_UNITS   = dp_pkg::NO_OF_UNITS,
   parameter int ADDR_W        = 10,
   parameter int HOLD_CYCLES   = 2,
   parameter int TIMEOUT       = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [ADDR_W-1:0]                      row_base,
   input  logic [ADDR_W-1:0]                      vec_base,
   input  logic [31:0]                            total,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   error,
   output logic [ELEMENT_WIDTH-1:0]               result,
   output logic                                   row_rd_en,
   output logic                                   vec_rd_en,
   output logic [ADDR_W-1:0]                      row_rd_addr,
   output logic [ADDR_W-1:0]                      vec_rd_addr,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   row_rd_data,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   vec_rd_data,
   output logic                                   dp_reset,
   output logic                                   dp_read_now,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   dp_first_row,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   dp_second_row,
   output logic [31:0]                            dp_total,
   input  logic [ELEMENT_WIDTH-1:0]               dp_result,
   input  logic                                   dp_finish
);

   import dp_pkg::*;

   localparam int PW        = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int LOG_UNITS = $clog2(NO_OF_UNITS);
   localparam int WCW       = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_nxt;
   logic              step;
   logic [WCW-1:0]    wait_cnt;
   logic              timed_out;
   logic [ADDR_W-1:0] row_base_q;
   logic [ADDR_W-1:0] vec_base_q;
   logic [ADDR_W-1:0] row_addr_last;
   logic [ADDR_W-1:0] vec_addr_last;
   logic [ADDR_W-1:0] word_off;
   logic [31:0]       total_q;
   logic              rd_en;
   logic              fetch_vld_p1;
   logic              pace_first;
   logic              pace_fetch;
   logic              pace_advance;
   logic              pace_last;
   logic [31:0]       pace_index;

   package_pacer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_pacer (
      .clk           (clk),
      .reset         (reset),
      .enable        (state == STREAM),
      .package_count (total_q >> LOG_UNITS),
      .first         (pace_first),
      .fetch         (pace_fetch),
      .advance       (pace_advance),
      .last_package  (pace_last),
      .index         (pace_index)
   );

   assign timed_out = (wait_cnt == WCW'(TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      done        = (state == DONE);
      dp_reset    = (state == CLEAR);
      dp_read_now = pace_first;
      rd_en       = ((state == PREFETCH) && !step) || pace_fetch;
      word_off    = '0;
      if (state == STREAM) begin
         word_off = ADDR_W'(pace_index + 32'd1);
      end
      row_rd_en   = rd_en;
      vec_rd_en   = rd_en;
      row_rd_addr = row_addr_last;
      vec_rd_addr = vec_addr_last;
      if (rd_en) begin
         row_rd_addr = row_base_q + word_off;
         vec_rd_addr = vec_base_q + word_off;
      end

      case (state)
         IDLE:     if (start) state_nxt = CHECK;
         CHECK:    state_nxt = total_ok(total_q, NO_OF_UNITS) ? CLEAR : DONE;
         CLEAR:    if (step) state_nxt = PREFETCH;
         PREFETCH: if (step) state_nxt = STREAM;
         STREAM:   if (pace_advance && pace_last) state_nxt = WAIT_RES;
         WAIT_RES: if (dp_finish || timed_out) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         step          <= 1'b0;
         wait_cnt      <= '0;
         fetch_vld_p1  <= 1'b0;
         row_base_q    <= '0;
         vec_base_q    <= '0;
         total_q       <= '0;
         dp_total      <= '0;
         error         <= 1'b0;
         result        <= '0;
         row_addr_last <= '0;
         vec_addr_last <= '0;
      end else begin
         state        <= state_nxt;
         // CLEAR and PREFETCH each last exactly two cycles.
         step         <= ((state == CLEAR) || (state == PREFETCH)) ? !step : 1'b0;
         wait_cnt     <= (state == WAIT_RES) ? wait_cnt + 1'b1 : '0;
         fetch_vld_p1 <= rd_en;

         if ((state == IDLE) && start) begin
            row_base_q <= row_base;
            vec_base_q <= vec_base;
            total_q    <= total;
            dp_total   <= total;
            error      <= 1'b0;
         end

         if ((state == CHECK) && !total_ok(total_q, NO_OF_UNITS)) begin
            error  <= 1'b1;
            result <= '0;
         end

         if (state == WAIT_RES) begin
            if (dp_finish) begin
               result <= dp_result;
               error  <= 1'b0;
            end else if (timed_out) begin
               error  <= 1'b1;
            end
         end

         if (rd_en) begin
            row_addr_last <= row_rd_addr;
            vec_addr_last <= vec_rd_addr;
         end
      end
   end

   // p1: RAM data is valid one cycle after the read; capture it only then, at the package boundary.
   always_ff @(posedge clk) begin
      if (reset || (pace_advance && pace_last)) begin
         dp_first_row  <= '0;
         dp_second_row <= '0;
      end else if (fetch_vld_p1) begin
         dp_first_row  <= row_rd_data[PW-1:0];
         dp_second_row <= vec_rd_data[PW-1:0];
      end
   end

endmodule

// File: tb/tb_dot_operand_streamer.sv
// Scoreboard bench for dot_operand_streamer: directed and random runs checked against a
// behavioural model of the RAMs, the package schedule and the result/done timing.
`timescale 1ns/1ps
module tb_dot_operand_streamer;

   localparam int EW    = 32;
   localparam int NU    = 8;
   localparam int PW    = EW * NU;
   localparam int AW    = 10;
   localparam int HC    = 2;
   localparam int TO    = 16;
   localparam int DEPTH = 1 << AW;
   localparam int NEVER = 32'h3FFF_FFFF;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] row_base = '0;
   logic [AW-1:0] vec_base = '0;
   logic [31:0]   total = '0;
   logic          busy, done, error;
   logic [EW-1:0] result;
   logic          row_rd_en, vec_rd_en;
   logic [AW-1:0] row_rd_addr, vec_rd_addr;
   logic [PW-1:0] row_rd_data = '0;
   logic [PW-1:0] vec_rd_data = '0;
   logic          dp_reset, dp_read_now;
   logic [PW-1:0] dp_first_row, dp_second_row;
   logic [31:0]   dp_total;
   logic [EW-1:0] dp_result = '0;
   logic          dp_finish = 1'b0;

   dot_operand_streamer #(
      .ELEMENT_WIDTH (EW),
      .NO_OF_UNITS   (NU),
      .ADDR_W        (AW),
      .HOLD_CYCLES   (HC),
      .TIMEOUT       (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .row_base      (row_base),
      .vec_base      (vec_base),
      .total         (total),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .result        (result),
      .row_rd_en     (row_rd_en),
      .vec_rd_en     (vec_rd_en),
      .row_rd_addr   (row_rd_addr),
      .vec_rd_addr   (vec_rd_addr),
      .row_rd_data   (row_rd_data),
      .vec_rd_data   (vec_rd_data),
      .dp_reset      (dp_reset),
      .dp_read_now   (dp_read_now),
      .dp_first_row  (dp_first_row),
      .dp_second_row (dp_second_row),
      .dp_total      (dp_total),
      .dp_result     (dp_result),
      .dp_finish     (dp_finish)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            start_cyc;
      int            done_cyc;
      int            s_cyc;
      int            p;
      bit            good;
      logic          err;
      logic [EW-1:0] res;
      logic [31:0]   tot;
   } exp_t;

   typedef struct {
      logic [PW-1:0] row;
      logic [PW-1:0] vec;
   } pkg_t;

   exp_t          exp_q[$];
   pkg_t          pkg_q[$];
   logic [AW-1:0] row_addr_q[$];
   logic [AW-1:0] vec_addr_q[$];

   logic [PW-1:0] row_mem [DEPTH];
   logic [PW-1:0] vec_mem [DEPTH];
   logic [EW-1:0] model_result = '0;
   int            finish_abs = NEVER;

   int n_cmp = 0;
   int n_bad = 0;
   int n_busy = 0, n_clr = 0, n_rn = 0;
   int stream_left = 0, hold = 0;
   bit zero_chk = 0;

   function automatic logic [PW-1:0] rnd_pkg();
      logic [PW-1:0] v;
      for (int i = 0; i < NU; i++) v[i*EW +: EW] = $urandom;
      return v;
   endfunction

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic flag(input string name, input logic [PW-1:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   // RAMs: data appears in the cycle after the enable, random junk otherwise.
   initial begin
      logic          pr, pv;
      logic [AW-1:0] ar, av;
      forever begin
         @(negedge clk);
         pr = row_rd_en; ar = row_rd_addr;
         pv = vec_rd_en; av = vec_rd_addr;
         @(posedge clk); #1;
         row_rd_data = pr ? row_mem[ar] : rnd_pkg();
         vec_rd_data = pv ? vec_mem[av] : rnd_pkg();
      end
   end

   // Engine stand-in: finish is a level that rises at the cycle chosen by the driver.
   initial begin
      forever begin
         @(posedge clk); #1;
         dp_finish = (cyc >= finish_abs);
      end
   end

   // Monitor: compares every read, every streamed package and every done against the queues.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (row_rd_en) begin
               if (row_addr_q.size() == 0) flag("row_read", row_rd_addr);
               else chk("row_rd_addr", row_rd_addr, row_addr_q.pop_front());
            end
            if (vec_rd_en) begin
               if (vec_addr_q.size() == 0) flag("vec_read", vec_rd_addr);
               else chk("vec_rd_addr", vec_rd_addr, vec_addr_q.pop_front());
            end
            if (dp_reset) n_clr++;
            if (busy) n_busy++;
            if (dp_read_now) begin
               n_rn++;
               if (exp_q.size() == 0 || !exp_q[0].good) flag("read_now", cyc);
               else begin
                  chk("read_now_cycle", cyc, exp_q[0].s_cyc);
                  stream_left = HC * exp_q[0].p;
                  hold = 0;
               end
            end
            if (stream_left > 0) begin
               if (pkg_q.size() == 0) flag("package", dp_first_row);
               else begin
                  chk("pkg_row", dp_first_row, pkg_q[0].row);
                  chk("pkg_vec", dp_second_row, pkg_q[0].vec);
               end
               hold++;
               if (hold == HC) begin
                  hold = 0;
                  if (pkg_q.size() != 0) void'(pkg_q.pop_front());
               end
               stream_left--;
               if (stream_left == 0) zero_chk = 1;
            end else if (zero_chk) begin
               zero_chk = 0;
               chk("pkg_zero_after_stream", dp_first_row | dp_second_row, '0);
            end
            if (done) begin
               if (exp_q.size() == 0) flag("done", result);
               else begin
                  e = exp_q.pop_front();
                  chk("done_cycle", cyc, e.done_cyc);
                  chk("error", error, e.err);
                  chk("result", result, e.res);
                  chk("dp_total", dp_total, e.tot);
                  chk("busy_cycles", n_busy, e.done_cyc - e.start_cyc);
                  chk("dp_reset_cycles", n_clr, e.good ? 2 : 0);
                  chk("read_now_count", n_rn, e.good ? 1 : 0);
                  chk("reads_missing", row_addr_q.size() + vec_addr_q.size(), 0);
               end
               n_busy = 0; n_clr = 0; n_rn = 0;
            end
         end
      end
   end

   task automatic flush();
      exp_q.delete(); pkg_q.delete(); row_addr_q.delete(); vec_addr_q.delete();
      stream_left = 0; hold = 0; zero_chk = 0;
      n_busy = 0; n_clr = 0; n_rn = 0;
      model_result = '0;
      finish_abs = NEVER;
   endtask

   task automatic issue(input int tot, input int rb, input int vb, input int fin_rel,
                        input logic [EW-1:0] res_val);
      exp_t e;
      int   w, f;
      @(posedge clk); #1;
      start = 1'b1; total = 32'(tot); row_base = AW'(rb); vec_base = AW'(vb);
      dp_result = res_val;
      finish_abs = (fin_rel < 0) ? NEVER : cyc + fin_rel;
      e.start_cyc = cyc;
      e.tot = 32'(tot);
      e.good = (tot != 0) && (tot % NU == 0);
      e.p = tot / NU;
      e.s_cyc = cyc + 6;
      if (!e.good) begin
         e.done_cyc = cyc + 2; e.err = 1'b1; e.res = '0;
         model_result = '0;
      end else begin
         w = e.s_cyc + HC * e.p;
         f = (finish_abs > w) ? finish_abs : w;
         if (f < w + TO) begin
            e.done_cyc = f + 1; e.err = 1'b0; e.res = res_val;
            model_result = res_val;
         end else begin
            e.done_cyc = w + TO; e.err = 1'b1; e.res = model_result;
         end
         for (int k = 0; k < e.p; k++) begin
            pkg_q.push_back('{row: row_mem[(rb + k) % DEPTH], vec: vec_mem[(vb + k) % DEPTH]});
            row_addr_q.push_back(AW'(rb + k));
            vec_addr_q.push_back(AW'(vb + k));
         end
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_busy();
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; total = 32'($urandom_range(1, 64)); row_base = AW'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drained();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("run_completes", exp_q.size(), 0);
      if (exp_q.size() != 0) flush();
      @(posedge clk); #1;
      finish_abs = NEVER;
   endtask

   task automatic check_idle(input string name);
      chk({name, "_busy_done_err"}, {busy, done, error}, '0);
      chk({name, "_result"}, result, '0);
      chk({name, "_rd_en"}, {row_rd_en, vec_rd_en}, '0);
      chk({name, "_rd_addr"}, {row_rd_addr, vec_rd_addr}, '0);
      chk({name, "_dp_ctrl"}, {dp_reset, dp_read_now}, '0);
      chk({name, "_packages"}, dp_first_row | dp_second_row, '0);
      chk({name, "_dp_total"}, dp_total, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, tot, r;
      for (int i = 0; i < DEPTH; i++) begin
         row_mem[i] = rnd_pkg();
         vec_mem[i] = rnd_pkg();
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      issue(16, 4, 0, 20, 32'h4120_0000);
      wait_drained();
      issue(8, 33, 44, -1, 32'h3F80_0000);
      wait_drained();
      issue(12, 7, 9, 8, 32'h1234_5678);
      wait_drained();
      issue(0, 7, 9, 8, 32'h1234_5678);
      wait_drained();
      issue(16, DEPTH - 1, DEPTH - 4, 9, 32'hC000_0000);
      wait_drained();

      // Abort in the middle of streaming.
      issue(16, 100, 200, -1, 32'h4000_0000);
      n = 0;
      while (!dp_read_now && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("read_now_before_abort", dp_read_now, 1'b1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      flush();
      @(negedge clk);
      check_idle("abort");

      issue(8, 5, 6, 12, 32'h4040_0000);
      pulse_busy();
      wait_drained();

      // start coinciding with reset must not launch a run.
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b1; total = 32'd8;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      flush();
      repeat (2) @(negedge clk);
      chk("start_with_reset_busy", busy, 1'b0);
      chk("start_with_reset_dp_total", dp_total, '0);

      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) tot = 0;
         else if (r == 1) tot = NU * $urandom_range(0, 4) + $urandom_range(1, NU - 1);
         else tot = NU * $urandom_range(1, 8);
         issue(tot, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
               ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(6, 6 + HC * 8 + TO + 4),
               $urandom);
         if (tot != 0 && tot % NU == 0 && $urandom_range(0, 2) == 0) pulse_busy();
         wait_drained();
      end

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
